apb_mig_bridge: RTL and testbench

APB_MIG_BRIDGE -- requirements
Module: apb_mig_bridge

---
 rtl/apb_mig_bridge.sv | 156 +++++++++++++++
 tb/tb_apb_mig_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mig_bridge.sv
// APB slave to Xilinx MIG user-interface bridge.
// One 32-bit APB word maps onto one lane of a 128-bit MIG burst.
module apb_mig_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MIG_ADDR_W = 28,
  parameter int MIG_DATA_W = 128
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic [ADDR_W-1:0]       paddr_i,
  input  logic [DATA_W-1:0]       pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [DATA_W/8-1:0]     pstrb_i,
  output logic [DATA_W-1:0]       prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic                    init_calib_complete_i,
  output logic [MIG_ADDR_W-1:0]   app_addr_o,
  output logic [2:0]              app_cmd_o,
  output logic                    app_en_o,
  input  logic                    app_rdy_i,
  output logic [MIG_DATA_W-1:0]   app_wdf_data_o,
  output logic [MIG_DATA_W/8-1:0] app_wdf_mask_o,
  output logic                    app_wdf_wren_o,
  output logic                    app_wdf_end_o,
  input  logic                    app_wdf_rdy_i,
  input  logic [MIG_DATA_W-1:0]   app_rd_data_i,
  input  logic                    app_rd_data_valid_i
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, WR, RD_CMD, RD_WAIT, RESP
  } state_t;

  state_t state, next;

  logic                  setup;
  logic                  err;
  logic                  cmd_ok;
  logic                  dat_ok;
  logic [1:0]            lane_q;
  logic [27:0]           addr_w;
  logic [MIG_DATA_W/8-1:0] wmask;
  logic [DATA_W-1:0]     rd_lane;

  assign setup  = psel_i & ~penable_i;
  assign err    = (paddr_i[1:0] != 2'b00)
                | ((paddr_i >> 28) != '0)
                | ~init_calib_complete_i;
  assign addr_w = {1'b0, paddr_i[27:4], 3'b000};
  // A strobe that is already low means its handshake finished earlier.
  assign cmd_ok = ~app_en_o | app_rdy_i;
  assign dat_ok = ~app_wdf_wren_o | app_wdf_rdy_i;

  // Byte mask: only the addressed lane is writable, under pstrb.
  always_comb begin
    wmask = '1;
    for (int i = 0; i < 4; i++) begin
      if (paddr_i[3:2] == 2'(i)) begin
        wmask[i*SW +: SW] = ~pstrb_i;
      end
    end
  end

  // Pick the addressed 32-bit lane out of the returned burst.
  always_comb begin
    rd_lane = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_q == 2'(i)) begin
        rd_lane = app_rd_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) state <= IDLE;
    else            state <= next;
  end

  // Next-state logic.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (setup) begin
          if (err)           next = RESP;
          else if (pwrite_i) next = WR;
          else               next = RD_CMD;
        end
      end
      WR:      if (cmd_ok && dat_ok)    next = RESP;
      RD_CMD:  if (app_rdy_i)           next = RD_WAIT;
      RD_WAIT: if (app_rd_data_valid_i) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Registered APB and MIG outputs.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      prdata_o       <= '0;
      pready_o       <= 1'b0;
      pslverr_o      <= 1'b0;
      app_en_o       <= 1'b0;
      app_wdf_wren_o <= 1'b0;
      app_wdf_end_o  <= 1'b0;
      app_cmd_o      <= 3'b000;
      app_addr_o     <= '0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '1;
      lane_q         <= 2'b00;
    end else begin
      pready_o <= (next == RESP);
      unique case (state)
        IDLE: begin
          if (setup) begin
            lane_q <= paddr_i[3:2];
            if (err) begin
              pslverr_o <= 1'b1;
              prdata_o  <= '0;
            end else begin
              pslverr_o  <= 1'b0;
              app_addr_o <= MIG_ADDR_W'(addr_w);
              app_cmd_o  <= pwrite_i ? 3'b000 : 3'b001;
              app_en_o   <= 1'b1;
              if (pwrite_i) begin
                app_wdf_wren_o <= 1'b1;
                app_wdf_end_o  <= 1'b1;
                app_wdf_data_o <= {4{pwdata_i}};
                app_wdf_mask_o <= wmask;
              end
            end
          end
        end
        WR: begin
          if (app_en_o && app_rdy_i) app_en_o <= 1'b0;
          if (app_wdf_wren_o && app_wdf_rdy_i) begin
            app_wdf_wren_o <= 1'b0;
            app_wdf_end_o  <= 1'b0;
          end
        end
        RD_CMD:  if (app_rdy_i) app_en_o <= 1'b0;
        RD_WAIT: if (app_rd_data_valid_i) prdata_o <= rd_lane;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Directed bench for apb_mig_bridge with a small MIG responder.
// Expected responses are queued by stimulus and checked by a monitor.
module tb_apb_mig_bridge;

  logic         pclk_i = 1'b0;
  logic         preset_ni;
  logic [31:0]  paddr_i;
  logic [31:0]  pwdata_i;
  logic         pwrite_i;
  logic         psel_i;
  logic         penable_i;
  logic [3:0]   pstrb_i;
  logic [31:0]  prdata_o;
  logic         pready_o;
  logic         pslverr_o;
  logic         init_calib_complete_i;
  logic [27:0]  app_addr_o;
  logic [2:0]   app_cmd_o;
  logic         app_en_o;
  logic         app_rdy_i;
  logic [127:0] app_wdf_data_o;
  logic [15:0]  app_wdf_mask_o;
  logic         app_wdf_wren_o;
  logic         app_wdf_end_o;
  logic         app_wdf_rdy_i;
  logic [127:0] app_rd_data_i;
  logic         app_rd_data_valid_i;

  apb_mig_bridge dut (
    .pclk_i                (pclk_i),
    .preset_ni             (preset_ni),
    .paddr_i               (paddr_i),
    .pwdata_i              (pwdata_i),
    .pwrite_i              (pwrite_i),
    .psel_i                (psel_i),
    .penable_i             (penable_i),
    .pstrb_i               (pstrb_i),
    .prdata_o              (prdata_o),
    .pready_o              (pready_o),
    .pslverr_o             (pslverr_o),
    .init_calib_complete_i (init_calib_complete_i),
    .app_addr_o            (app_addr_o),
    .app_cmd_o             (app_cmd_o),
    .app_en_o              (app_en_o),
    .app_rdy_i             (app_rdy_i),
    .app_wdf_data_o        (app_wdf_data_o),
    .app_wdf_mask_o        (app_wdf_mask_o),
    .app_wdf_wren_o        (app_wdf_wren_o),
    .app_wdf_end_o         (app_wdf_end_o),
    .app_wdf_rdy_i         (app_wdf_rdy_i),
    .app_rd_data_i         (app_rd_data_i),
    .app_rd_data_valid_i   (app_rd_data_valid_i)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    int          lat;
    int          en;
    int          wr;
  } resp_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [27:0] addr;
  } cmd_t;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  m;
  } wr_t;

  resp_t resp_q[$];
  cmd_t  cmd_q[$];
  wr_t   wr_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int setup_cyc = 0;

  int rdy_delay = 0;
  int wdf_delay = 0;
  int rd_lat    = 5;
  logic [127:0] rd_word = '0;
  int rd_cnt = 0;
  int en_age = 0;
  int wdf_age = 0;

  int en_n = 0;
  int wr_n = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock, plus the MIG responder behaviour for the new cycle.
  task automatic cycle();
    bit rd_hs;
    rd_hs = app_en_o && app_rdy_i && (app_cmd_o == 3'b001);
    @(posedge pclk_i);
    cyc++;
    #1;
    app_rd_data_valid_i = 1'b0;
    if (rd_hs) begin
      rd_cnt = rd_lat;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 1) begin
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i = rd_word;
        rd_cnt = 0;
      end
    end
    if (app_en_o) begin
      en_age++;
      app_rdy_i = (en_age > rdy_delay);
    end else begin
      en_age = 0;
      app_rdy_i = 1'b0;
    end
    if (app_wdf_wren_o) begin
      wdf_age++;
      app_wdf_rdy_i = (wdf_age > wdf_delay);
    end else begin
      wdf_age = 0;
      app_wdf_rdy_i = 1'b0;
    end
  endtask

  task automatic apb(input logic [31:0] a, input logic [31:0] d,
                     input bit wr, input logic [3:0] s);
    int n;
    paddr_i = a;
    pwdata_i = d;
    pwrite_i = wr;
    pstrb_i = s;
    psel_i = 1'b1;
    penable_i = 1'b0;
    setup_cyc = cyc + 1;
    cycle();
    penable_i = 1'b1;
    n = 0;
    while (!pready_o && n < 64) begin
      cycle();
      n++;
    end
    chk("apb_no_timeout", (n < 64), 1);
    cycle();
    psel_i = 1'b0;
    penable_i = 1'b0;
    cycle();
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_pready"}, pready_o, 0);
    chk({t, "_pslverr"}, pslverr_o, 0);
    chk({t, "_prdata"}, prdata_o, 0);
    chk({t, "_app_en"}, app_en_o, 0);
    chk({t, "_wren"}, app_wdf_wren_o, 0);
    chk({t, "_wend"}, app_wdf_end_o, 0);
    chk({t, "_cmd"}, app_cmd_o, 0);
    chk({t, "_addr"}, app_addr_o, 0);
    chk({t, "_wdata"}, app_wdf_data_o, 0);
    chk({t, "_mask"}, app_wdf_mask_o, 16'hFFFF);
  endtask

  function automatic resp_t mk(input bit e, input bit r,
                               input logic [31:0] rd, input int l,
                               input int en, input int w);
    resp_t x;
    x.err = e; x.rd = r; x.rdata = rd;
    x.lat = l; x.en = en; x.wr = w;
    return x;
  endfunction

  // Monitor: handshakes and APB responses against the queues.
  always @(negedge pclk_i) begin
    if (!preset_ni) begin
      en_n = 0;
      wr_n = 0;
    end else begin
      if (app_en_o) en_n++;
      if (app_wdf_wren_o) wr_n++;
      if (app_en_o && app_rdy_i) begin
        if (cmd_q.size() == 0) begin
          chk("unexp_cmd", app_en_o, 0);
        end else begin
          cmd_t c;
          c = cmd_q.pop_front();
          chk("cmd", app_cmd_o, c.cmd);
          chk("app_addr", app_addr_o, c.addr);
        end
      end
      if (app_wdf_wren_o && app_wdf_rdy_i) begin
        if (wr_q.size() == 0) begin
          chk("unexp_wdf", app_wdf_wren_o, 0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wdf_data", app_wdf_data_o, w.d);
          chk("wdf_mask", app_wdf_mask_o, w.m);
          chk("wdf_end", app_wdf_end_o, 1);
        end
      end
      if (pready_o) begin
        if (resp_q.size() == 0) begin
          chk("unexp_pready", pready_o, 0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("pslverr", pslverr_o, r.err);
          if (r.rd || r.err) chk("prdata", prdata_o, r.rdata);
          chk("latency", cyc - setup_cyc, r.lat);
          chk("app_en_cycles", en_n, r.en);
          chk("wren_cycles", wr_n, r.wr);
        end
        en_n = 0;
        wr_n = 0;
      end
    end
  end

  initial begin
    preset_ni = 1'b0;
    paddr_i = '0;
    pwdata_i = '0;
    pwrite_i = 1'b0;
    psel_i = 1'b0;
    penable_i = 1'b0;
    pstrb_i = '0;
    init_calib_complete_i = 1'b1;
    app_rdy_i = 1'b0;
    app_wdf_rdy_i = 1'b0;
    app_rd_data_i = '0;
    app_rd_data_valid_i = 1'b0;

    cycle();
    cycle();
    chk_rst("rst");
    preset_ni = 1'b1;
    cycle();

    // Full-word write to lane 2.
    cmd_q.push_back('{3'b000, 28'h8});
    wr_q.push_back('{{4{32'hDEADBEEF}}, 16'hF0FF});
    resp_q.push_back(mk(0, 0, 0, 1, 1, 1));
    apb(32'h18, 32'hDEADBEEF, 1, 4'hF);

    // Read lane 1, data five cycles after the command.
    rd_lat = 5;
    rd_word = {32'h33333333, 32'h22222222, 32'h12345678, 32'h0};
    cmd_q.push_back('{3'b001, 28'h0});
    resp_q.push_back(mk(0, 1, 32'h12345678, 6, 1, 0));
    apb(32'h4, 32'h0, 0, 4'hF);

    // Command accept delayed three cycles.
    rdy_delay = 3;
    cmd_q.push_back('{3'b000, 28'h10});
    wr_q.push_back('{{4{32'hA5A50F0F}}, 16'hFFCF});
    resp_q.push_back(mk(0, 0, 0, 4, 4, 1));
    apb(32'h24, 32'hA5A50F0F, 1, 4'h3);
    rdy_delay = 0;

    // Write-data accept delayed two cycles.
    wdf_delay = 2;
    cmd_q.push_back('{3'b000, 28'h18});
    wr_q.push_back('{{4{32'h01020304}}, 16'hFFF3});
    resp_q.push_back(mk(0, 0, 0, 3, 1, 3));
    apb(32'h30, 32'h01020304, 1, 4'hC);
    wdf_delay = 0;

    // Error cases: high address, misaligned, calibration not done.
    resp_q.push_back(mk(1, 1, 32'h0, 0, 0, 0));
    apb(32'h1000_0000, 32'h0, 0, 4'hF);
    resp_q.push_back(mk(1, 0, 32'h0, 0, 0, 0));
    apb(32'h2, 32'hFFFFFFFF, 1, 4'hF);
    init_calib_complete_i = 1'b0;
    resp_q.push_back(mk(1, 1, 32'h0, 0, 0, 0));
    apb(32'h8, 32'h0, 0, 4'hF);
    init_calib_complete_i = 1'b1;

    // Zero-strobe write is fully masked but still completes.
    cmd_q.push_back('{3'b000, 28'h0});
    wr_q.push_back('{{4{32'h55AA55AA}}, 16'hFFFF});
    resp_q.push_back(mk(0, 0, 0, 1, 1, 1));
    apb(32'hC, 32'h55AA55AA, 1, 4'h0);

    // Highest legal address, lane 3.
    rd_lat = 2;
    rd_word = {32'hA1B2C3D4, 32'h2, 32'h1, 32'h0};
    cmd_q.push_back('{3'b001, 28'h7FFFFF8});
    resp_q.push_back(mk(0, 1, 32'hA1B2C3D4, 3, 1, 0));
    apb(32'h0FFF_FFFC, 32'h0, 0, 4'h0);

    // Reset while waiting for read data.
    rd_lat = 20;
    cmd_q.push_back('{3'b001, 28'h0});
    paddr_i = 32'h4;
    pwrite_i = 1'b0;
    psel_i = 1'b1;
    penable_i = 1'b0;
    cycle();
    penable_i = 1'b1;
    cycle();
    cycle();
    preset_ni = 1'b0;
    #1;
    chk_rst("rst_mid");
    psel_i = 1'b0;
    penable_i = 1'b0;
    rd_cnt = 0;
    cycle();
    preset_ni = 1'b1;
    cycle();
    app_rd_data_i = {32'h0, 32'h0, 32'hBADBAD01, 32'h0};
    app_rd_data_valid_i = 1'b1;
    cycle();
    cycle();
    chk("late_prdata", prdata_o, 0);
    chk("late_pready", pready_o, 0);

    // Next read after reset.
    rd_lat = 3;
    rd_word = {32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    cmd_q.push_back('{3'b001, 28'h0});
    resp_q.push_back(mk(0, 1, 32'hCAFEF00D, 4, 1, 0));
    apb(32'h4, 32'h0, 0, 4'hF);

    cycle();
    chk("resp_q_left", resp_q.size(), 0);
    chk("cmd_q_left", cmd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
